// File: rtl/l2_req_arb.sv
// l2_req_arb: round-robin merge of nstreams stream-pointer host requests onto one
// host request port, with tag-based routing of host responses back to the streams.
//
// Optional feature macro: L2_REQ_ARB_CREDIT_EN
//   defined   -> outstanding-request credit counter limits in-flight requests to max_outst
//   undefined -> no counter; a credit is always available
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   i_req_v/i_req_r/i_req_ea : per-stream request handshake and address (stream k at
//                           bits [k*addr_width +: addr_width])
//   o_req_v/o_req_r/o_req_ea/o_req_tag : merged registered host request, tag = stream index
//   i_rsp_v/i_rsp_r/i_rsp_tag : host response in
//   o_rsp_v/o_rsp_r       : per-stream response delivery
//   o_idle                : nothing buffered (and, with credits, nothing outstanding)
module l2_req_arb #(
    parameter int unsigned nstreams   = 8,
    parameter int unsigned addr_width = 64,
    parameter int unsigned max_outst  = 64,
    localparam int unsigned sid_width = $clog2(nstreams)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [nstreams-1:0]              i_req_v,
    output logic [nstreams-1:0]              i_req_r,
    input  logic [nstreams*addr_width-1:0]   i_req_ea,
    output logic                             o_req_v,
    input  logic                             o_req_r,
    output logic [addr_width-1:0]            o_req_ea,
    output logic [sid_width-1:0]             o_req_tag,
    input  logic                             i_rsp_v,
    output logic                             i_rsp_r,
    input  logic [sid_width-1:0]             i_rsp_tag,
    output logic [nstreams-1:0]              o_rsp_v,
    input  logic [nstreams-1:0]              o_rsp_r,
    output logic                             o_idle
);

    if (max_outst == 0) begin : g_bad_cfg
        $error("l2_req_arb: max_outst must be non-zero");
    end

    logic                  o_req_v_q, o_req_v_d;
    logic [addr_width-1:0] o_req_ea_q, o_req_ea_d;
    logic [sid_width-1:0]  o_req_tag_q, o_req_tag_d;
    logic [sid_width-1:0]  last_q, last_d;

    logic                  grant_found;
    logic [sid_width-1:0]  grant_idx;
    logic [sid_width-1:0]  cand_idx;
    int unsigned           cand;
    logic                  can_load;
    logic                  credit_ok;
    logic                  req_accept;
    logic                  tag_ok;

    // Round-robin search starting one past the last granted stream.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned i = 1; i <= nstreams; i++) begin
            cand     = (32'(last_q) + i) % nstreams;
            cand_idx = cand[sid_width-1:0];
            if (!grant_found && i_req_v[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Output register may load when empty or when its content leaves this cycle.
    assign can_load   = ~o_req_v_q | o_req_r;
    assign req_accept = grant_found & can_load & credit_ok;

    always_comb begin
        i_req_r = '0;
        if (req_accept) begin
            i_req_r[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        o_req_v_d   = o_req_v_q;
        o_req_ea_d  = o_req_ea_q;
        o_req_tag_d = o_req_tag_q;
        last_d      = last_q;
        if (req_accept) begin
            o_req_v_d   = 1'b1;
            o_req_ea_d  = i_req_ea[32'(grant_idx) * addr_width +: addr_width];
            o_req_tag_d = grant_idx;
            last_d      = grant_idx;
        end else if (o_req_r) begin
            o_req_v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req_v_q   <= 1'b0;
            o_req_ea_q  <= '0;
            o_req_tag_q <= '0;
            last_q      <= sid_width'(nstreams - 1);
        end else begin
            o_req_v_q   <= o_req_v_d;
            o_req_ea_q  <= o_req_ea_d;
            o_req_tag_q <= o_req_tag_d;
            last_q      <= last_d;
        end
    end

    assign o_req_v   = o_req_v_q;
    assign o_req_ea  = o_req_ea_q;
    assign o_req_tag = o_req_tag_q;

    // Tags beyond the stream count only exist when nstreams is not a power of two.
    if (nstreams == (32'd1 << sid_width)) begin : g_tag_full
        assign tag_ok = 1'b1;
    end else begin : g_tag_partial
        assign tag_ok = (32'(i_rsp_tag) < nstreams);
    end

    always_comb begin
        o_rsp_v = '0;
        if (i_rsp_v && tag_ok) begin
            o_rsp_v[i_rsp_tag] = 1'b1;
        end
    end

    // Responses to non-existent streams are accepted and dropped.
    assign i_rsp_r = tag_ok ? o_rsp_r[i_rsp_tag] : 1'b1;

`ifdef L2_REQ_ARB_CREDIT_EN
    localparam int unsigned cnt_width = $clog2(max_outst + 1);

    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 cnt_inc, cnt_dec;

    assign cnt_inc = req_accept;
    // Never underflow: responses can still arrive after a reset dropped their requests.
    assign cnt_dec = i_rsp_v & i_rsp_r & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + cnt_width'(1);
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - cnt_width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign credit_ok = (cnt_q != cnt_width'(max_outst));
    assign o_idle    = ~o_req_v_q & (cnt_q == '0);
`else
    assign credit_ok = 1'b1;
    assign o_idle    = ~o_req_v_q;
`endif

endmodule

// File: tb/tb_l2_req_arb.sv
module tb_l2_req_arb;

    localparam int NS   = 8;
    localparam int AW   = 64;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS-1:0]   i_req_v;
    logic [NS-1:0]   i_req_r;
    logic [NS*AW-1:0] i_req_ea;
    logic            o_req_v;
    logic            o_req_r;
    logic [AW-1:0]   o_req_ea;
    logic [2:0]      o_req_tag;
    logic            i_rsp_v;
    logic            i_rsp_r;
    logic [2:0]      i_rsp_tag;
    logic [NS-1:0]   o_rsp_v;
    logic [NS-1:0]   o_rsp_r;
    logic            o_idle;

    // Second instance with 6 streams so that out-of-range tags (6, 7) are expressible.
    logic [5:0]  d2_i_req_r;
    logic        d2_o_req_v;
    logic [7:0]  d2_o_req_ea;
    logic [2:0]  d2_o_req_tag;
    logic        d2_i_rsp_r;
    logic [5:0]  d2_o_rsp_v;
    logic        d2_o_idle;
    logic        d2_i_rsp_v;
    logic [2:0]  d2_i_rsp_tag;
    logic [5:0]  d2_o_rsp_r;

    always #5 clk = ~clk;

    l2_req_arb #(.nstreams(NS), .addr_width(AW), .max_outst(MAXO)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (i_req_v),
        .i_req_r   (i_req_r),
        .i_req_ea  (i_req_ea),
        .o_req_v   (o_req_v),
        .o_req_r   (o_req_r),
        .o_req_ea  (o_req_ea),
        .o_req_tag (o_req_tag),
        .i_rsp_v   (i_rsp_v),
        .i_rsp_r   (i_rsp_r),
        .i_rsp_tag (i_rsp_tag),
        .o_rsp_v   (o_rsp_v),
        .o_rsp_r   (o_rsp_r),
        .o_idle    (o_idle)
    );

    l2_req_arb #(.nstreams(6), .addr_width(8), .max_outst(MAXO)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (6'b0),
        .i_req_r   (d2_i_req_r),
        .i_req_ea  (48'b0),
        .o_req_v   (d2_o_req_v),
        .o_req_r   (1'b1),
        .o_req_ea  (d2_o_req_ea),
        .o_req_tag (d2_o_req_tag),
        .i_rsp_v   (d2_i_rsp_v),
        .i_rsp_r   (d2_i_rsp_r),
        .i_rsp_tag (d2_i_rsp_tag),
        .o_rsp_v   (d2_o_rsp_v),
        .o_rsp_r   (d2_o_rsp_r),
        .o_idle    (d2_o_idle)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_last;
    bit          m_full;
    logic [63:0] m_ea;
    int          m_tag;
    int          m_cnt;
    // Per-cycle predictions reused when the model advances
    int          p_win;
    logic [7:0]  p_rdy;
    logic        p_rsp_r;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = NS - 1;
        m_full = 1'b0;
        m_ea   = '0;
        m_tag  = 0;
        m_cnt  = 0;
    endtask

    task automatic check_model();
        bit         can_load;
        bit         credit;
        logic [7:0] exp_rsp_v;
        p_win = -1;
        for (int j = 1; j <= NS; j++) begin
            int k;
            k = (m_last + j) % NS;
            if (p_win < 0 && i_req_v[k]) p_win = k;
        end
        can_load = !m_full || o_req_r;
`ifdef L2_REQ_ARB_CREDIT_EN
        credit = (m_cnt < MAXO);
`else
        credit = 1'b1;
`endif
        p_rdy     = (p_win >= 0 && can_load && credit) ? (8'd1 << p_win) : 8'd0;
        p_rsp_r   = o_rsp_r[i_rsp_tag];
        exp_rsp_v = i_rsp_v ? (8'd1 << i_rsp_tag) : 8'd0;
        chk("i_req_r", 64'(i_req_r), 64'(p_rdy));
        chk("o_req_v", 64'(o_req_v), 64'(m_full));
        if (m_full) begin
            chk("o_req_ea", o_req_ea, m_ea);
            chk("o_req_tag", 64'(o_req_tag), 64'(m_tag));
        end
        chk("o_idle", 64'(o_idle), 64'(!m_full && m_cnt == 0));
        chk("o_rsp_v", 64'(o_rsp_v), 64'(exp_rsp_v));
        chk("i_rsp_r", 64'(i_rsp_r), 64'(p_rsp_r));
    endtask

    task automatic update_model();
        bit acc;
        bit racc;
        acc  = (p_rdy != 8'd0);
        racc = i_rsp_v && p_rsp_r;
        if (acc) begin
            m_full = 1'b1;
            m_ea   = i_req_ea[p_win*AW +: AW];
            m_tag  = p_win;
            m_last = p_win;
        end else if (o_req_r) begin
            m_full = 1'b0;
        end
`ifdef L2_REQ_ARB_CREDIT_EN
        m_cnt = m_cnt + int'(acc) - int'(racc && m_cnt > 0);
`endif
    endtask

    // Inputs are driven at posedge+1; outputs are checked at posedge+2.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_o_req_v", 64'(o_req_v), 64'd0);
        chk("rst_o_idle", 64'(o_idle), 64'd1);
        chk("rst_o_req_tag", 64'(o_req_tag), 64'd0);
        chk("rst_o_req_ea", o_req_ea, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_ea(input int k, input logic [63:0] val);
        i_req_ea[k*AW +: AW] = val;
    endtask

    initial begin
        reset        = 1'b1;
        i_req_v      = '0;
        i_req_ea     = '0;
        o_req_r      = 1'b0;
        i_rsp_v      = 1'b0;
        i_rsp_tag    = '0;
        o_rsp_r      = '0;
        d2_i_rsp_v   = 1'b0;
        d2_i_rsp_tag = '0;
        d2_o_rsp_r   = '0;
        for (int k = 0; k < NS; k++) set_ea(k, 64'h100 * (k + 1));
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // All streams requesting: tags rotate 0..7 then 0, first valid one cycle after accept.
        i_req_v   = 8'hFF;
        o_req_r   = 1'b1;
        i_rsp_v   = 1'b1;
        i_rsp_tag = 3'd0;
        o_rsp_r   = 8'hFF;
        #1;
        chk("rr_first_v", 64'(o_req_v), 64'd0);
        for (int n = 0; n < 9; n++) begin
            tick();
            chk("rr_tag", 64'(o_req_tag), 64'(n % NS));
            chk("rr_v", 64'(o_req_v), 64'd1);
        end
        i_req_v = '0;
        i_rsp_v = 1'b0;
        tick();
        tick();

        // Single requester is served back-to-back.
        do_reset();
        i_req_v = 8'h20;
        o_req_r = 1'b1;
        set_ea(5, 64'h1000);
        tick();
        set_ea(5, 64'h1080);
        chk("solo_tag0", 64'(o_req_tag), 64'd5);
        chk("solo_ea0", o_req_ea, 64'h1000);
        tick();
        i_req_v = '0;
        chk("solo_tag1", 64'(o_req_tag), 64'd5);
        chk("solo_ea1", o_req_ea, 64'h1080);
        chk("solo_v1", 64'(o_req_v), 64'd1);
        tick();
        set_ea(5, 64'h600);

        // Back-pressure holds stream 2 stable; stream 3 goes next on release.
        do_reset();
        i_req_v = 8'h0C;
        o_req_r = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("hold_tag", 64'(o_req_tag), 64'd2);
            chk("hold_ea", o_req_ea, 64'h300);
            chk("hold_v", 64'(o_req_v), 64'd1);
        end
        o_req_r = 1'b1;
        tick();
        chk("release_tag", 64'(o_req_tag), 64'd3);
        chk("release_ea", o_req_ea, 64'h400);
        i_req_v = '0;
        tick();
        tick();

        // Response routing and dropping of out-of-range tags.
        i_rsp_v   = 1'b1;
        i_rsp_tag = 3'd6;
        o_rsp_r   = 8'h00;
        #1;
        chk("rsp_v6", 64'(o_rsp_v), 64'h40);
        chk("rsp_r6_low", 64'(i_rsp_r), 64'd0);
        o_rsp_r = 8'h40;
        #1;
        chk("rsp_r6_high", 64'(i_rsp_r), 64'd1);
        i_rsp_v      = 1'b0;
        o_rsp_r      = 8'h00;
        d2_i_rsp_v   = 1'b1;
        d2_i_rsp_tag = 3'd7;
        d2_o_rsp_r   = 6'h00;
        #1;
        chk("drop_r", 64'(d2_i_rsp_r), 64'd1);
        chk("drop_v", 64'(d2_o_rsp_v), 64'd0);
        d2_i_rsp_tag = 3'd4;
        #1;
        chk("d2_rsp_v4", 64'(d2_o_rsp_v), 64'h10);
        chk("d2_rsp_r4", 64'(d2_i_rsp_r), 64'd0);
        d2_i_rsp_v = 1'b0;
        tick();

`ifdef L2_REQ_ARB_CREDIT_EN
        // Credit limit: four in flight blocks grants until one response returns.
        do_reset();
        i_req_v = 8'hFF;
        o_req_r = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        #1;
        chk("cred_block_r", 64'(i_req_r), 64'd0);
        chk("cred_block_idle", 64'(o_idle), 64'd0);
        tick();
        i_rsp_v   = 1'b1;
        i_rsp_tag = 3'd0;
        o_rsp_r   = 8'hFF;
        tick();
        i_rsp_v = 1'b0;
        #1;
        chk("cred_one_more", 64'(i_req_r), 64'h10);
        tick();
        #1;
        chk("cred_block_again", 64'(i_req_r), 64'd0);
        tick();
`endif

        // Reset mid-operation with a buffered request and three in flight.
        do_reset();
        i_req_v = 8'hFF;
        o_req_r = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        o_req_r = 1'b0;
        #1;
        chk("pre_rst_v", 64'(o_req_v), 64'd1);
        do_reset();
        o_req_r = 1'b1;
        tick();
        chk("post_rst_tag", 64'(o_req_tag), 64'd0);
        chk("post_rst_v", 64'(o_req_v), 64'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            i_req_v   = 8'($urandom);
            o_req_r   = 1'($urandom);
            i_rsp_v   = 1'($urandom);
            i_rsp_tag = 3'($urandom);
            o_rsp_r   = 8'($urandom);
            for (int k = 0; k < NS; k++) set_ea(k, {$urandom, $urandom});
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
